// File: rtl/countdown_timer.sv
// Purpose: M:SS down-counting timer with programmable step per tick, flags expiry at 0:00.
// Latency: all outputs registered; load/state changes visible one edge after the request.
// Backpressure: none; count=0 pauses the countdown and holds the prescaler in place.
module countdown_timer #(
  parameter int TICK_DIV = 1,
  parameter int DW       = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          count,
  input  logic [DW-1:0] subtractor,
  input  logic [DW-1:0] load_minutes0,
  input  logic [DW-1:0] load_seconds1,
  input  logic [DW-1:0] load_seconds0,
  output logic [DW-1:0] minutes0,
  output logic [DW-1:0] seconds1,
  output logic [DW-1:0] seconds0,
  output logic          running,
  output logic          done
);

  // A one-bit prescaler is kept even when TICK_DIV=1 so the counter always has a legal width.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e        state_q;
  logic [DW-1:0] min_q, sec1_q, sec0_q;
  logic [PW-1:0] presc_q;
  logic          running_q, done_q;

  logic [DW-1:0] ld_min_d, ld_sec1_d, ld_sec0_d;
  logic          ld_nz_d;
  logic [9:0]    t_cur, t_step, t_rem;
  logic          tick, expire;
  logic [DW-1:0] dec_min_d, dec_sec1_d, dec_sec0_d;
  logic [PW-1:0] presc_d;

  // Clamp loaded digits to a legal M:SS value; an all-zero value parks the timer in IDLE.
  always_comb begin
    ld_min_d  = (load_minutes0 > DW'(9)) ? DW'(9) : load_minutes0;
    ld_sec1_d = (load_seconds1 > DW'(5)) ? DW'(5) : load_seconds1;
    ld_sec0_d = (load_seconds0 > DW'(9)) ? DW'(9) : load_seconds0;
    ld_nz_d   = (ld_min_d != '0) || (ld_sec1_d != '0) || (ld_sec0_d != '0);
  end

  // Work in total seconds so the step can borrow across minute and tens boundaries freely.
  always_comb begin
    t_cur      = 10'(min_q) * 10'd60 + 10'(sec1_q) * 10'd10 + 10'(sec0_q);
    t_step     = 10'(subtractor);
    t_rem      = t_cur - t_step;
    expire     = (t_cur <= t_step);
    dec_min_d  = DW'(t_rem / 10'd60);
    dec_sec1_d = DW'((t_rem % 10'd60) / 10'd10);
    dec_sec0_d = DW'(t_rem % 10'd10);
    tick       = (presc_q == PW'(TICK_DIV - 1));
    presc_d    = tick ? '0 : presc_q + PW'(1);
  end

  // Control FSM: load wins over counting; running/done move on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      min_q     <= '0;
      sec1_q    <= '0;
      sec0_q    <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (load) begin
      min_q     <= ld_min_d;
      sec1_q    <= ld_sec1_d;
      sec0_q    <= ld_sec0_d;
      presc_q   <= '0;
      state_q   <= ld_nz_d ? S_HOLD : S_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          // Entering RUN never ticks; the first tick is evaluated once state is RUN.
          if (count) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (!count) begin
            // Pause keeps the prescaler phase so a resume continues mid-period.
            state_q   <= S_HOLD;
            running_q <= 1'b0;
          end else begin
            presc_q <= presc_d;
            if (tick && (subtractor != '0)) begin
              if (!expire) begin
                min_q  <= dec_min_d;
                sec1_q <= dec_sec1_d;
                sec0_q <= dec_sec0_d;
              end else begin
                // Saturate at 0:00 instead of wrapping.
                min_q     <= '0;
                sec1_q    <= '0;
                sec0_q    <= '0;
                state_q   <= S_DONE;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end
          end
        end
        default: begin
          // IDLE and DONE ignore count; only load or reset leave them.
        end
      endcase
    end
  end

  assign minutes0 = min_q;
  assign seconds1 = sec1_q;
  assign seconds0 = sec0_q;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Purpose: randomized + directed bench for countdown_timer at TICK_DIV=1 and TICK_DIV=4.
// Latency: reference model predicts each edge; monitor compares 1 time unit after the edge.
// Backpressure: none; inputs driven on negedge, outputs always valid every cycle.
module tb_countdown_timer;

  typedef struct packed {
    logic [5:0] m;
    logic [5:0] s1;
    logic [5:0] s0;
    logic       run;
    logic       dn;
  } exp_t;

  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       count = 1'b0;
  logic [5:0] subtractor = '0;
  logic [5:0] lm = '0, ls1 = '0, ls0 = '0;

  logic [5:0] m_a, s1_a, s0_a, m_b, s1_b, s0_b;
  logic       run_a, dn_a, run_b, dn_b;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state, in total seconds, for instance 0 (div 1) and 1 (div 4).
  int t_m[2];
  int st_m[2];
  int pre_m[2];
  exp_t q0[$];
  exp_t q1[$];

  countdown_timer #(.TICK_DIV(1), .DW(6)) dut_a (
    .clk(clk), .reset(reset), .load(load), .count(count), .subtractor(subtractor),
    .load_minutes0(lm), .load_seconds1(ls1), .load_seconds0(ls0),
    .minutes0(m_a), .seconds1(s1_a), .seconds0(s0_a), .running(run_a), .done(dn_a));

  countdown_timer #(.TICK_DIV(4), .DW(6)) dut_b (
    .clk(clk), .reset(reset), .load(load), .count(count), .subtractor(subtractor),
    .load_minutes0(lm), .load_seconds1(ls1), .load_seconds0(ls0),
    .minutes0(m_b), .seconds1(s1_b), .seconds0(s0_b), .running(run_b), .done(dn_b));

  always #5 clk = ~clk;

  function automatic exp_t mk(int m, int s1, int s0, bit r, bit d);
    exp_t e;
    e.m = 6'(m); e.s1 = 6'(s1); e.s0 = 6'(s0); e.run = r; e.dn = d;
    return e;
  endfunction

  function automatic exp_t model_out(int i);
    return mk(t_m[i] / 60, (t_m[i] % 60) / 10, t_m[i] % 10,
              st_m[i] == M_RUN, st_m[i] == M_DONE);
  endfunction

  function automatic int clampi(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_step(int i);
    int div;
    bit tk;
    div = (i == 0) ? 1 : 4;
    if (!reset) begin
      t_m[i] = 0; st_m[i] = M_IDLE; pre_m[i] = 0;
    end else if (load) begin
      t_m[i] = clampi(int'(lm), 9) * 60 + clampi(int'(ls1), 5) * 10 + clampi(int'(ls0), 9);
      pre_m[i] = 0;
      st_m[i] = (t_m[i] != 0) ? M_HOLD : M_IDLE;
    end else if (st_m[i] == M_HOLD) begin
      if (count) st_m[i] = M_RUN;
    end else if (st_m[i] == M_RUN) begin
      if (!count) st_m[i] = M_HOLD;
      else begin
        tk = (pre_m[i] == div - 1);
        pre_m[i] = (pre_m[i] + 1) % div;
        if (tk && subtractor != 0) begin
          if (t_m[i] > int'(subtractor)) t_m[i] = t_m[i] - int'(subtractor);
          else begin
            t_m[i] = 0; st_m[i] = M_DONE;
          end
        end
      end
    end
  endfunction

  task automatic chk(string name, exp_t got, exp_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d:%0d%0d run=%0b done=%0b, want %0d:%0d%0d run=%0b done=%0b",
                  name, got.m, got.s1, got.s0, got.run, got.dn,
                  want.m, want.s1, want.s0, want.run, want.dn);
  endtask

  // Model: predict every edge and queue the expected outputs of both instances.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  end

  // Monitor: pop and compare after each edge, independently of the stimulus.
  always @(posedge clk) begin
    #1;
    if (q0.size() == 0 || q1.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard: queue empty, got size %0d/%0d, want nonzero", q0.size(), q1.size());
    end else begin
      chk("sb_div1", {m_a, s1_a, s0_a, run_a, dn_a}, q0.pop_front());
      chk("sb_div4", {m_b, s1_b, s0_b, run_b, dn_b}, q1.pop_front());
    end
  end

  task automatic cyc(input logic ld, input logic cnt, input logic [5:0] sub,
                     input logic [5:0] m, input logic [5:0] s1, input logic [5:0] s0);
    @(negedge clk);
    load = ld; count = cnt; subtractor = sub; lm = m; ls1 = s1; ls0 = s0;
    @(posedge clk);
    #2;
  endtask

  function automatic exp_t got_a();
    return {m_a, s1_a, s0_a, run_a, dn_a};
  endfunction

  function automatic exp_t got_b();
    return {m_b, s1_b, s0_b, run_b, dn_b};
  endfunction

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 1: 0:25 step 1 down to expiry
    cyc(1, 0, 1, 0, 2, 5);
    cyc(0, 1, 1, 0, 0, 0);
    chk("t1_run_after_count", got_a(), mk(0, 2, 5, 1, 0));
    repeat (24) cyc(0, 1, 1, 0, 0, 0);
    chk("t1_at_0_01", got_a(), mk(0, 0, 1, 1, 0));
    cyc(0, 1, 1, 0, 0, 0);
    chk("t1_done", got_a(), mk(0, 0, 0, 0, 1));
    repeat (3) cyc(0, 1, 1, 0, 0, 0);
    chk("t1_done_sticky", got_a(), mk(0, 0, 0, 0, 1));

    // 2: minute borrow, then pause and resume
    cyc(1, 0, 1, 1, 0, 5);
    chk("t2_load_done_drops", got_a(), mk(1, 0, 5, 0, 0));
    cyc(0, 1, 1, 0, 0, 0);
    repeat (6) cyc(0, 1, 1, 0, 0, 0);
    chk("t2_borrow", got_a(), mk(0, 5, 9, 1, 0));
    repeat (20) cyc(0, 0, 1, 0, 0, 0);
    chk("t2_paused", got_a(), mk(0, 5, 9, 0, 0));
    repeat (10) cyc(0, 1, 1, 0, 0, 0);

    // 3: saturation with step 8, then step 0 while running
    cyc(1, 0, 8, 0, 2, 0);
    cyc(0, 1, 8, 0, 0, 0);
    cyc(0, 1, 8, 0, 0, 0);
    chk("t3_0_12", got_a(), mk(0, 1, 2, 1, 0));
    cyc(0, 1, 8, 0, 0, 0);
    chk("t3_0_04", got_a(), mk(0, 0, 4, 1, 0));
    cyc(0, 1, 8, 0, 0, 0);
    chk("t3_saturate", got_a(), mk(0, 0, 0, 0, 1));
    cyc(1, 0, 0, 0, 2, 0);
    repeat (6) cyc(0, 1, 0, 0, 0, 0);
    chk("t3_step0", got_a(), mk(0, 2, 0, 1, 0));

    // 4: TICK_DIV=4, step 15, pause at prescaler 2
    cyc(1, 0, 15, 9, 5, 9);
    cyc(0, 1, 15, 0, 0, 0);
    repeat (4) cyc(0, 1, 15, 0, 0, 0);
    chk("t4_first_tick", got_b(), mk(9, 4, 4, 1, 0));
    repeat (2) cyc(0, 1, 15, 0, 0, 0);
    cyc(0, 0, 15, 0, 0, 0);
    cyc(0, 1, 15, 0, 0, 0);
    cyc(0, 1, 15, 0, 0, 0);
    chk("t4_resume_no_tick", got_b(), mk(9, 4, 4, 1, 0));
    cyc(0, 1, 15, 0, 0, 0);
    chk("t4_resume_tick", got_b(), mk(9, 2, 9, 1, 0));

    // 5: clamping, zero load, load with count
    cyc(1, 0, 1, 7, 7, 12);
    chk("t5_clamp", got_a(), mk(7, 5, 9, 0, 0));
    cyc(1, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 1, 1, 0, 0, 0);
    chk("t5_idle_ignores_count", got_a(), mk(0, 0, 0, 0, 0));
    cyc(1, 1, 1, 0, 3, 0);
    chk("t5_load_count_hold", got_a(), mk(0, 3, 0, 0, 0));
    cyc(0, 1, 1, 0, 0, 0);
    chk("t5_then_run", got_a(), mk(0, 3, 0, 1, 0));

    // 6: asynchronous reset mid-run
    repeat (3) cyc(0, 1, 1, 0, 0, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t6_async_div1", got_a(), mk(0, 0, 0, 0, 0));
    chk("t6_async_div4", got_b(), mk(0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) cyc(0, 1, 1, 0, 0, 0);
    chk("t6_no_count_after_reset", got_a(), mk(0, 0, 0, 0, 0));

    // Randomized phase
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 199) != 0);
      load       = ($urandom_range(0, 24) == 0);
      count      = ($urandom_range(0, 4) != 0);
      subtractor = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
      lm         = 6'($urandom_range(0, 15));
      ls1        = 6'($urandom_range(0, 7));
      ls0        = 6'($urandom_range(0, 15));
    end
    @(negedge clk);
    reset = 1'b1; load = 1'b0; count = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
